// File: rtl/lfsr_y_keystream_ctrl_pkg.sv
// Shared definitions for the Y-register LFSR keystream controller.
// State encoding and LFSR geometry used by the controller and its neighbours.
package lfsr_y_keystream_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam int LFSR_W     = 22;
    localparam int LFSR_TAP_A = 20;
    localparam int LFSR_TAP_B = 21;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lfsr_y_keystream_ctrl.sv
// Seeds and warms up the Y-register LFSR, then XORs each pixel with Y[0:PIX_W-1].
// One LFSR step per accepted pixel, landing in a gap cycle before the next accept.
module lfsr_y_keystream_ctrl
    import lfsr_y_keystream_ctrl_pkg::*;
#(
    parameter int KEY_W  = 22,
    parameter int WARMUP = 32,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    output logic              busy,
    output logic              keyed,
    output logic              lfsr_shift_bit,
    output logic              lfsr_trigger,
    input  logic [0:LFSR_W-1] lfsr_y,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data
);

    localparam int CNT_W = $clog2(max_i(KEY_W, WARMUP) + 1);

    state_t           state;
    logic [KEY_W-1:0] key_q;
    logic [CNT_W-1:0] cnt;
    logic             gap;
    logic             accept;
    logic [PIX_W-1:0] keystream;
    logic             unused_y;

    assign keystream = lfsr_y[0:PIX_W-1];
    assign unused_y  = ^lfsr_y[PIX_W:LFSR_W-1];

    assign s_ready = (state == ST_RUN) && !gap && (!m_valid || m_ready);
    assign accept  = s_valid && s_ready;

    // key_q shifts left so its MSB is always the next seed bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            key_q          <= '0;
            cnt            <= '0;
            gap            <= 1'b0;
            busy           <= 1'b0;
            keyed          <= 1'b0;
            lfsr_shift_bit <= 1'b0;
            lfsr_trigger   <= 1'b0;
            m_valid        <= 1'b0;
            m_data         <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_SEED;
                        key_q          <= key << 1;
                        cnt            <= CNT_W'(KEY_W - 1);
                        busy           <= 1'b1;
                        lfsr_trigger   <= 1'b1;
                        lfsr_shift_bit <= key[KEY_W-1];
                    end
                end
                ST_SEED: begin
                    if (cnt != '0) begin
                        cnt            <= cnt - 1'b1;
                        key_q          <= key_q << 1;
                        lfsr_shift_bit <= key_q[KEY_W-1];
                    end else if (WARMUP > 0) begin
                        state          <= ST_WARMUP;
                        cnt            <= CNT_W'(WARMUP - 1);
                        lfsr_shift_bit <= 1'b0;
                    end else begin
                        state          <= ST_RUN;
                        busy           <= 1'b0;
                        keyed          <= 1'b1;
                        lfsr_trigger   <= 1'b0;
                        lfsr_shift_bit <= 1'b0;
                    end
                end
                ST_WARMUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state        <= ST_RUN;
                        busy         <= 1'b0;
                        keyed        <= 1'b1;
                        lfsr_trigger <= 1'b0;
                    end
                end
                ST_RUN: begin
                    lfsr_trigger   <= 1'b0;
                    lfsr_shift_bit <= 1'b0;
                    gap            <= 1'b0;
                    if (accept) begin
                        m_data       <= s_data ^ keystream;
                        m_valid      <= 1'b1;
                        gap          <= 1'b1;
                        lfsr_trigger <= 1'b1;
                    end else begin
                        if (m_valid && m_ready) begin
                            m_valid <= 1'b0;
                        end
                        // re-seed only with nothing in flight
                        if (start && !m_valid && !gap) begin
                            state          <= ST_SEED;
                            keyed          <= 1'b0;
                            busy           <= 1'b1;
                            key_q          <= key << 1;
                            cnt            <= CNT_W'(KEY_W - 1);
                            lfsr_trigger   <= 1'b1;
                            lfsr_shift_bit <= key[KEY_W-1];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_y_keystream_ctrl.sv
// Bench for lfsr_y_keystream_ctrl: Y-register LFSR beside the DUT plus a model.
// Directed seeding, encryption, backpressure, start collisions and resets.
module tb_lfsr_y_keystream_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [21:0] key = '0;
    logic        busy;
    logic        keyed;
    logic        lfsr_shift_bit;
    logic        lfsr_trigger;
    logic [0:21] y_reg;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;

    int          n_chk = 0;
    int          n_err = 0;
    int          trig_cnt = 0;
    logic        sbq[$];
    logic [0:21] model = '0;
    logic [0:21] y_s2 = '0;

    lfsr_y_keystream_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key),
        .busy(busy), .keyed(keyed),
        .lfsr_shift_bit(lfsr_shift_bit), .lfsr_trigger(lfsr_trigger),
        .lfsr_y(y_reg),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    // Y-register LFSR: new bit enters Y[0], feedback from taps 20 and 21
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) y_reg <= '0;
        else if (lfsr_trigger)
            y_reg <= {lfsr_shift_bit ^ y_reg[20] ^ y_reg[21], y_reg[0:20]};
    end

    always @(negedge clk) begin
        if (lfsr_trigger) begin
            trig_cnt++;
            sbq.push_back(lfsr_shift_bit);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    function automatic logic [0:21] lstep(input logic [0:21] s, input logic b);
        return {b ^ s[20] ^ s[21], s[0:20]};
    endfunction

    function automatic logic [7:0] ks(input logic [0:21] s);
        logic [7:0] r;
        r = s[0:7];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outs"},
            {24'd0, busy, keyed, lfsr_shift_bit, lfsr_trigger, s_ready, m_valid, 2'b0}, 32'd0);
        chk({tag, "_mdata"}, m_data, 32'd0);
        chk({tag, "_y"}, y_reg, 32'd0);
    endtask

    task automatic do_seed(input logic [21:0] k, input bit collide);
        int          n;
        int          t0;
        logic [21:0] bits;
        logic        tail;
        t0 = trig_cnt;
        sbq.delete();
        key = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("seed_busy", busy, 1);
        n = 0;
        while (!keyed && n < 200) begin
            if (collide && n == 5) begin
                key = '0;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
        end
        #1;
        chk("seed_cycles", n, 54);
        chk("seed_trig", trig_cnt - t0, 54);
        chk("seed_nbits", sbq.size(), 54);
        bits = '0;
        tail = 1'b0;
        for (int i = 0; i < sbq.size(); i++) begin
            if (i < 22) bits = {bits[20:0], sbq[i]};
            else tail |= sbq[i];
        end
        chk("seed_bits", bits, k);
        chk("warm_bits", tail, 0);
        chk("seed_done", {busy, keyed}, 2'b01);
        for (int i = 21; i >= 0; i--) model = lstep(model, k[i]);
        for (int i = 0; i < 32; i++) model = lstep(model, 1'b0);
        chk("seed_y", y_reg, model);
    endtask

    task automatic send_pix(input logic [7:0] p);
        int         w;
        logic [7:0] e;
        w = 0;
        while (!s_ready && w < 20) begin
            tick();
            w++;
        end
        chk("pix_wait", s_ready, 1);
        e = p ^ ks(model);
        s_valid = 1'b1;
        s_data = p;
        tick();
        s_valid = 1'b0;
        chk("pix_mvalid", m_valid, 1);
        chk("pix_mdata", m_data, e);
        chk("pix_gap", {lfsr_trigger, lfsr_shift_bit, s_ready}, 3'b100);
        model = lstep(model, 1'b0);
    endtask

    initial begin
        logic [7:0] pix [3];
        logic [7:0] held;
        int         t0;
        pix[0] = 8'hA5;
        pix[1] = 8'h00;
        pix[2] = 8'hFF;

        // reset with random inputs
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom);
            key = 22'($urandom);
            s_valid = 1'($urandom);
            s_data = 8'($urandom);
            m_ready = 1'($urandom);
            tick();
            chk_zero("reset");
        end
        start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk_zero("post_reset");

        // seed and warm-up
        do_seed(22'h2AAAAA, 1'b0);
        y_s2 = model;

        // encrypt a short stream at full rate
        m_ready = 1'b1;
        t0 = trig_cnt;
        for (int i = 0; i < 3; i++) begin
            send_pix(pix[i]);
            tick();
            chk("enc_clear", m_valid, 0);
            chk("enc_y", y_reg, model);
            chk("enc_ready", s_ready, 1);
        end
        chk("enc_trig", trig_cnt - t0, 3);

        // backpressure
        m_ready = 1'b0;
        t0 = trig_cnt;
        send_pix(8'h3C);
        held = m_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {m_valid, s_ready, lfsr_trigger}, 3'b100);
            chk("bp_data", m_data, held);
        end
        chk("bp_trig", trig_cnt - t0, 1);
        chk("bp_y", y_reg, model);
        m_ready = 1'b1;
        tick();
        chk("bp_release", m_valid, 0);
        chk("bp_next_ready", s_ready, 1);
        send_pix(8'h81);
        tick();

        // start while output pending is ignored
        m_ready = 1'b0;
        t0 = trig_cnt;
        send_pix(8'h5A);
        key = 22'h155555;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("col_state", {busy, keyed, m_valid}, 3'b011);
        chk("col_trig", trig_cnt - t0, 1);
        m_ready = 1'b1;
        tick();
        chk("col_drain", m_valid, 0);

        // re-seed from RUN, with an ignored start mid-SEED
        do_seed(22'h0F0F0F, 1'b1);

        // reset mid-SEED
        key = 22'h2AAAAA;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset_n = 1'b0;
        #1;
        chk_zero("rst_seed");
        tick();
        reset_n = 1'b1;
        tick();
        model = '0;
        do_seed(22'h2AAAAA, 1'b0);
        chk("rerun1_y", y_reg, y_s2);

        // reset mid-RUN with output pending
        m_ready = 1'b0;
        send_pix(8'hC3);
        tick();
        reset_n = 1'b0;
        #1;
        chk_zero("rst_run");
        tick();
        reset_n = 1'b1;
        tick();
        model = '0;
        do_seed(22'h2AAAAA, 1'b0);
        chk("rerun2_y", y_reg, y_s2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
